// File: rtl/soc_mem_resp.sv
// Word-addressed 32-bit memory responder with a WAIT_CYCLES wait-state FSM and a one-cycle ready pulse.
// Optional out-of-range checking on upper address bits is enabled by defining SOC_MEMRESP_ERR_EN.
module soc_mem_resp #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] dtw,
   input  logic        rw,
   input  logic        valid,
   output logic        ready,
   output logic [31:0] dtr,
   output logic        err,
   output logic [1:0]  o_dbg_state
);

   // Handshake: the initiator holds valid (with addr/dtw/rw stable) until it sees
   // ready; the request is captured on the first IDLE edge with valid=1, and
   // ready is a single-cycle completion pulse that may not be stalled.

   localparam int        DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] WC   = WAIT_CYCLES[3:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [3:0]              r_cnt;
   logic [31:0]             r_addr;
   logic [31:0]             r_dtw;
   logic                    r_rw;
   logic [31:0]             r_dtr;
   logic                    r_err;
   logic [31:0]             r_mem [DEPTH];

   logic                    w_enter_resp;
   logic [31:0]             w_addr;
   logic [31:0]             w_dtw;
   logic                    w_rw;
   logic [ADDR_WIDTH-1:0]   w_idx;
   logic                    w_oob;
   logic                    w_unused;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (valid) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // With zero wait states the access happens on the capture edge itself, so the
   // live inputs stand in for the (identical) values being latched on that edge.
   assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
   assign w_addr       = (r_state == S_IDLE) ? addr : r_addr;
   assign w_dtw        = (r_state == S_IDLE) ? dtw  : r_dtw;
   assign w_rw         = (r_state == S_IDLE) ? rw   : r_rw;
   assign w_idx        = w_addr[ADDR_WIDTH+1:2];
   assign w_unused     = ^{w_addr[1:0], w_addr[31:ADDR_WIDTH+2]};

`ifdef SOC_MEMRESP_ERR_EN
   assign w_oob = |(w_addr >> (ADDR_WIDTH + 2));
`else
   assign w_oob = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 32'h0;
         r_dtw   <= 32'h0;
         r_rw    <= 1'b0;
         r_dtr   <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && valid) begin
            r_addr <= addr;
            r_dtw  <= dtw;
            r_rw   <= rw;
            r_cnt  <= WC;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         r_err <= w_enter_resp & w_oob;
         if (w_enter_resp && !w_rw) r_dtr <= w_oob ? 32'h0 : r_mem[w_idx];
      end
   end

   // Array has no reset; a reset edge also suppresses any commit on that edge.
   always_ff @(posedge clk) begin
      if (reset && w_enter_resp && w_rw && !w_oob) r_mem[w_idx] <= w_dtw;
   end

   assign ready       = (r_state == S_RESP);
   assign dtr         = r_dtr;
   assign err         = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_soc_mem_resp.sv
// Self-checking bench for soc_mem_resp: three instances (WAIT_CYCLES 1, 0, 3) with a
// reference memory model and an expected-read-data queue. Honors SOC_MEMRESP_ERR_EN.
module tb_soc_mem_resp;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] dtw;
   logic        rw;
   logic [2:0]  valid;
   logic [2:0]  ready;
   logic [31:0] dtr [3];
   logic [2:0]  err;
   logic [1:0]  st [3];

   logic [31:0] model_mem [3][256];
   logic [31:0] last_dtr [3];
   logic [31:0] exp_q [$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   soc_mem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut0 (
      .clk(clk), .reset(reset), .addr(addr), .dtw(dtw), .rw(rw), .valid(valid[0]),
      .ready(ready[0]), .dtr(dtr[0]), .err(err[0]), .o_dbg_state(st[0]));
   soc_mem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .reset(reset), .addr(addr), .dtw(dtw), .rw(rw), .valid(valid[1]),
      .ready(ready[1]), .dtr(dtr[1]), .err(err[1]), .o_dbg_state(st[1]));
   soc_mem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_dut2 (
      .clk(clk), .reset(reset), .addr(addr), .dtw(dtw), .rw(rw), .valid(valid[2]),
      .ready(ready[2]), .dtr(dtr[2]), .err(err[2]), .o_dbg_state(st[2]));

   function automatic int wc(input int k);
      case (k)
         0: return 1;
         1: return 0;
         default: return 3;
      endcase
   endfunction

   function automatic logic exp_oob(input logic [31:0] a);
`ifdef SOC_MEMRESP_ERR_EN
      return (a >> 10) != 0;
`else
      return (a >> 32) != 0;
`endif
   endfunction

   // One complete transfer on instance k; optional alt changes the inputs after capture.
   task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit alt, input logic [31:0] a2);
      logic        e_err;
      int          idx;
      int          lat;
      logic [31:0] e_dtr;
      e_err = exp_oob(a);
      idx   = (a >> 2) & 255;
      if (!w) exp_q.push_back(e_err ? 32'h0 : model_mem[k][idx]);
      else if (!e_err) model_mem[k][idx] = d;
      @(negedge clk);
      addr = a; dtw = d; rw = w; valid[k] = 1'b1;
      @(posedge clk);
      #1;
      if (alt) begin
         addr = a2; dtw = ~d; rw = ~w;
      end
      lat = -1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (ready[k]) begin
            lat = j;
            break;
         end
         n_cmp++;
         if (err[k] !== 1'b0) begin
            n_err++;
            $display("FAIL err_idle dut%0d: got %b want 0", k, err[k]);
         end
      end
      valid[k] = 1'b0;
      n_cmp++;
      if (lat != wc(k)) begin
         n_err++;
         $display("FAIL latency dut%0d addr=%h: got %0d want %0d", k, a, lat, wc(k));
      end
      if (!w) e_dtr = exp_q.pop_front();
      else e_dtr = last_dtr[k];
      if (lat >= 0) begin
         n_cmp++;
         if (err[k] !== e_err) begin
            n_err++;
            $display("FAIL err dut%0d addr=%h: got %b want %b", k, a, err[k], e_err);
         end
         n_cmp++;
         if (dtr[k] !== e_dtr) begin
            n_err++;
            $display("FAIL dtr dut%0d addr=%h rw=%b: got %h want %h", k, a, w, dtr[k], e_dtr);
         end
      end
      last_dtr[k] = e_dtr;
   endtask

   task automatic test_reset;
      reset = 1'b0; valid = 3'b000; addr = 32'h0; dtw = 32'h0; rw = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (ready[k] !== 1'b0 || dtr[k] !== 32'h0 || err[k] !== 1'b0 || st[k] !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state dut%0d: ready=%b dtr=%h err=%b st=%0d want 0/0/0/0",
                     k, ready[k], dtr[k], err[k], st[k]);
         end
         last_dtr[k] = 32'h0;
      end
      reset = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (ready[k] !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_reset dut%0d: got %b want 0", k, ready[k]);
         end
      end
   endtask

   task automatic test_write_read;
      logic [31:0] a [6];
      logic [31:0] d;
      xfer(0, 1'b1, 32'h10, 32'hCAFEBABE, 1'b0, 32'h0);
      xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
      xfer(1, 1'b1, 32'h4, 32'hAAAA0000, 1'b0, 32'h0);
      xfer(1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         a[i] = 32'($urandom_range(0, 255)) << 2;
         d    = $urandom;
         xfer(2, 1'b1, a[i], d, 1'b0, 32'h0);
      end
      for (int i = 5; i >= 0; i--) xfer(2, 1'b0, a[i], 32'h0, 1'b0, 32'h0);
      xfer(2, 1'b1, 32'h3FC, 32'h0BADCAFE, 1'b0, 32'h0);
      xfer(2, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic test_stability;
      for (int k = 0; k < 3; k += 2) begin
         xfer(k, 1'b1, 32'h8, 32'h11111111, 1'b0, 32'h0);
         xfer(k, 1'b1, 32'hC, 32'h22222222, 1'b0, 32'h0);
         xfer(k, 1'b0, 32'h8, 32'h0, 1'b1, 32'hC);
         xfer(k, 1'b1, 32'h8, 32'h33333333, 1'b1, 32'hC);
         xfer(k, 1'b0, 32'hC, 32'h0, 1'b0, 32'h0);
         xfer(k, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0);
      end
   endtask

   // valid held high: ready must recur every WAIT_CYCLES+2 cycles.
   task automatic test_back_to_back(input int k, input logic [31:0] a);
      int          p;
      logic        e_r;
      logic [31:0] e_d;
      p = wc(k) + 2;
      @(negedge clk);
      addr = a; rw = 1'b0; dtw = 32'h0; valid[k] = 1'b1;
      @(posedge clk);
      for (int j = 0; j <= 2 * p + wc(k); j++) begin
         @(negedge clk);
         e_r = ((j % p) == wc(k));
         if (e_r) exp_q.push_back(model_mem[k][(a >> 2) & 255]);
         n_cmp++;
         if (ready[k] !== e_r) begin
            n_err++;
            $display("FAIL b2b_ready dut%0d cycle %0d: got %b want %b", k, j, ready[k], e_r);
         end
         if (ready[k] === 1'b1) begin
            e_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            n_cmp++;
            if (dtr[k] !== e_d) begin
               n_err++;
               $display("FAIL b2b_dtr dut%0d cycle %0d: got %h want %h", k, j, dtr[k], e_d);
            end
            last_dtr[k] = e_d;
         end
      end
      valid[k] = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset_abort;
      xfer(2, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, 32'h0);
      @(negedge clk);
      addr = 32'h20; dtw = 32'hDEADBEEF; rw = 1'b1; valid[2] = 1'b1;
      @(posedge clk);
      #1;
      valid[2] = 1'b0;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         n_cmp++;
         if (ready[2] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_wait_ready cycle %0d: got %b want 0", j, ready[2]);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) last_dtr[k] = 32'h0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         n_cmp++;
         if (ready[2] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_ready cycle %0d: got %b want 0", j, ready[2]);
         end
      end
      xfer(2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic test_upper_addr;
      xfer(0, 1'b1, 32'h000, 32'h0F0F0F0F, 1'b0, 32'h0);
      xfer(0, 1'b1, 32'h400, 32'h12345678, 1'b0, 32'h0);
      xfer(0, 1'b0, 32'h000, 32'h0, 1'b0, 32'h0);
      xfer(0, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
      xfer(0, 1'b1, 32'h404, 32'h55AA55AA, 1'b0, 32'h0);
      xfer(0, 1'b0, 32'h004, 32'h0, 1'b0, 32'h0);
      xfer(0, 1'b0, 32'h80000004, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_stability;
      test_back_to_back(1, 32'h4);
      test_back_to_back(0, 32'h10);
      test_back_to_back(2, 32'h3FC);
      test_reset_abort;
      test_upper_addr;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/soc_mem_resp.md
SOC_MEM_RESP -- requirements
Module: soc_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning word-address width; the array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning wait states inserted before each access.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port addr  input  32  byte address from the initiator; addr[1:0] ignored.
REQ-006 SHALL have port dtw  input  32  write data from the initiator.
REQ-007 SHALL have port rw  input  1  transfer direction: 1 write, 0 read.
REQ-008 SHALL have port valid  input  1  initiator request, held high until ready is seen.
REQ-009 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port dtr  output  32  read data, valid while ready=1 after a read.
REQ-011 SHALL have port err  output  1  out-of-range flag, pulses with ready; present only per REQ-027.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-013 In IDLE with valid=1 at an edge, SHALL latch addr, dtw and rw, load the wait counter with WAIT_CYCLES, and go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-014 In WAIT, SHALL decrement the counter once per cycle and move to RESP on the edge at which the counter reads 1.
REQ-015 SHALL perform the array access (write commit or read fetch) on the edge that enters RESP, using only the latched request fields.
REQ-016 SHALL assert ready for exactly one cycle while in RESP, then return unconditionally to IDLE.
REQ-017 Read/write latency SHALL be WAIT_CYCLES+1 cycles: a request sampled at edge T gives ready=1 in the cycle after edge T+WAIT_CYCLES.
REQ-018 SHALL ignore valid in WAIT and RESP; changes to addr, dtw and rw after the capture edge have no effect.
REQ-019 Back-to-back: a valid still high in the first IDLE cycle after RESP SHALL be captured as a new request; peak throughput is one transfer per WAIT_CYCLES+2 cycles.
REQ-020 dtr SHALL update only on read completions and hold its value otherwise, including across writes.
REQ-021 Word index SHALL be addr[ADDR_WIDTH+1:2].
REQ-022 Writes SHALL update all 32 bits; there are no byte enables.

Reset
REQ-023 With reset=0 at an edge, SHALL go to IDLE with ready=0, dtr=32'h0, err=0 and counter=0.
REQ-024 Reset during WAIT SHALL abort the transfer; the pending write is not committed and no ready is issued.
REQ-025 Reset SHALL NOT clear the array contents.
REQ-026 ready SHALL be 0 in the first cycle after reset is released.

Configuration
REQ-027 With macro SOC_MEMRESP_ERR_EN defined: a request with any nonzero bit in addr[31:ADDR_WIDTH+2] SHALL complete with normal latency, commit no write, return dtr=32'h0 on a read, and pulse err=1 together with ready.
REQ-028 Without SOC_MEMRESP_ERR_EN: upper address bits SHALL be ignored (aliasing), and err SHALL be tied to 0.

Verification
REQ-029 Write then read, WAIT_CYCLES=1: write addr=0x10 dtw=0xCAFEBABE, then read addr=0x10 -> ready 2 cycles after each capture edge, and dtr=0xCAFEBABE on the read.
REQ-030 Zero wait, WAIT_CYCLES=0: read addr=0x4 after writing 0xAAAA0000 -> ready in the cycle after the capture edge with dtr=0xAAAA0000; hold valid high -> second capture in the next cycle, spacing 2 cycles.
REQ-031 Input stability: change addr from 0x8 to 0xC during WAIT, with word 2 = 0x11111111 -> dtr=0x11111111.
REQ-032 Reset mid-operation, WAIT_CYCLES=3: write 0xDEADBEEF to 0x20, pull reset low in the 2nd WAIT cycle, then read 0x20 -> old contents returned, and no ready during the aborted transfer.
REQ-033 SOC_MEMRESP_ERR_EN with ADDR_WIDTH=8: write 0x12345678 to 0x400 -> err=1 with ready; read 0x000 -> unchanged data with err=0; read 0x400 -> dtr=0, err=1.
REQ-034 No SOC_MEMRESP_ERR_EN: write 0x55AA55AA to 0x404, then read 0x004 -> dtr=0x55AA55AA, err=0 throughout.
